// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch stage of the 16-bit SIMPLE processor.
//
// Holds the PC, fetches one instruction at a time from instruction memory
// over a req/ready handshake, and presents it to the decoder/controller on
// instr/instr_valid until the controller acknowledges it. On acknowledge the
// controller's halt/branch decode of that instruction is applied. A single
// exec pulse starts the unit from IDLE; an exec pulse while running requests
// a pause that takes effect at the next acknowledge.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   exec                  run/pause request pulse
//   imem_req/imem_addr    fetch request and address (address always = pc)
//   imem_ready/imem_rdata memory completion and fetched word
//   instr/instr_valid     current instruction (0 when not valid)
//   instr_ack             controller consumed instr this cycle
//   halt, pc_src          controller decode of instr (HLT / taken branch)
//   branch_target         redirect address, used with pc_src
//   pc_out                address of the instruction on instr
//   running               high while in REQ, WAIT or HOLD
module instr_fetch_unit #(
  parameter int unsigned           ADDR_W   = 16,
  parameter int unsigned           DATA_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              halt,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic              running
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                pause_pending_q, pause_pending_d;

  // NOTE: every state variable is given its current value first, so any path
  // that does not assign it holds the flop instead of inferring a latch.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_out_d        = pc_out_q;
    instr_d         = instr_q;
    instr_valid_d   = instr_valid_q;
    pause_pending_d = pause_pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (exec) state_d = S_REQ;
      end

      S_REQ, S_WAIT: begin
        // A pause never aborts the fetch in flight; it is remembered instead.
        if (exec) pause_pending_d = 1'b1;
        if (imem_ready) begin
          instr_d       = imem_rdata;
          pc_out_d      = pc_q;
          pc_d          = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else begin
          state_d       = S_WAIT;
        end
      end

      S_HOLD: begin
        if (!instr_ack) begin
          if (exec) pause_pending_d = 1'b1;
        end else if (halt) begin
          // halt wins over branch and pause; pc is left untouched.
          instr_valid_d   = 1'b0;
          instr_d         = '0;
          pause_pending_d = 1'b0;
          state_d         = S_HALTED;
        end else begin
          // pc already points past this instruction; a taken branch replaces it.
          if (pc_src) pc_d = branch_target;
          instr_valid_d = 1'b0;
          instr_d       = '0;
          if (pause_pending_q || exec) begin
            pause_pending_d = 1'b0;
            state_d         = S_IDLE;
          end else begin
            state_d         = S_REQ;
          end
        end
      end

      S_HALTED: begin
        // Only reset leaves this state.
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      pc_out_q        <= '0;
      instr_q         <= '0;
      instr_valid_q   <= 1'b0;
      pause_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_out_q        <= pc_out_d;
      instr_q         <= instr_d;
      instr_valid_q   <= instr_valid_d;
      pause_pending_q <= pause_pending_d;
    end
  end

  // instr_q is cleared whenever instr_valid drops, so instr reads 0 (NOP)
  // whenever nothing valid is presented.
  assign imem_req    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign running     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (state_q == S_HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a table of per-cycle vectors for the
// zero-wait pipeline, ack stall, branch and halt behaviour, plus hand-written
// sequences for wait states, pause, async reset and PC wrap (second instance
// with RESET_PC = 0xFFFF).
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec, instr_ack, halt, pc_src;
  logic [15:0] branch_target;
  logic        imem_req, imem_ready, instr_valid, running;
  logic [15:0] imem_addr, imem_rdata, instr, pc_out;

  // Second instance for the wrap-around case.
  logic        exec2, ack2;
  logic        imem_req2, instr_valid2, running2;
  logic [15:0] imem_addr2, imem_rdata2, instr2, pc_out2;

  int errors = 0;
  int checks = 0;
  int wait_cfg = 0;
  int wcnt = 0;

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      default:  return a ^ 16'hBEEF;
    endcase
  endfunction

  // Memory model: answers after wait_cfg wait cycles.
  always @(posedge clock) begin
    if (!imem_req || imem_ready) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end
  assign imem_ready  = imem_req && (wcnt == wait_cfg);
  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) u_dut (
    .clock(clock), .reset(reset), .exec(exec),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .halt(halt), .pc_src(pc_src), .branch_target(branch_target),
    .pc_out(pc_out), .running(running)
  );

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
    .clock(clock), .reset(reset), .exec(exec2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_req2), .imem_rdata(imem_rdata2),
    .instr(instr2), .instr_valid(instr_valid2), .instr_ack(ack2),
    .halt(1'b0), .pc_src(1'b0), .branch_target(16'h0000),
    .pc_out(pc_out2), .running(running2)
  );

  typedef struct {
    logic        exec, ack, halt, pc_src;
    logic [15:0] target;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr, e_pc_out;
    logic        e_run;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic ex, ak, hl, ps, input logic [15:0] tg,
                         input logic rq, input logic [15:0] ad, input logic vl,
                         input logic [15:0] in, po, input logic rn);
    vec_t v;
    v.exec = ex; v.ack = ak; v.halt = hl; v.pc_src = ps; v.target = tg;
    v.e_req = rq; v.e_addr = ad; v.e_valid = vl; v.e_instr = in;
    v.e_pc_out = po; v.e_run = rn;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    step();
    step();
    @(negedge clock) reset = 1'b1;
    step();
  endtask

  task automatic chk_main(input string tag, input logic rq, input logic [15:0] ad,
                          input logic vl, input logic [15:0] in, po, input logic rn);
    check({tag, " imem_req"},    32'(imem_req),    32'(rq));
    check({tag, " imem_addr"},   32'(imem_addr),   32'(ad));
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(vl));
    check({tag, " instr"},       32'(instr),       32'(in));
    check({tag, " pc_out"},      32'(pc_out),      32'(po));
    check({tag, " running"},     32'(running),     32'(rn));
  endtask

  initial begin
    reset = 1'b0; exec = 1'b0; instr_ack = 1'b0; halt = 1'b0; pc_src = 1'b0;
    branch_target = 16'h0000; exec2 = 1'b0; ack2 = 1'b1;
    step();
    step();

    // Reset state of both instances.
    chk_main("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("wrap reset imem_addr", 32'(imem_addr2), 32'h0000FFFF);
    check("wrap reset pc_out",    32'(pc_out2),    32'h0);
    check("wrap reset running",   32'(running2),   32'h0);
    @(negedge clock) reset = 1'b1;
    step();

    // PC wrap: RESET_PC=0xFFFF fetches 0xFFFF then 0x0000.
    exec2 = 1'b1;
    step();
    exec2 = 1'b0;
    check("wrap req0 addr",  32'(imem_addr2), 32'h0000FFFF);
    check("wrap req0 req",   32'(imem_req2),  32'h1);
    step();
    check("wrap f0 valid",   32'(instr_valid2), 32'h1);
    check("wrap f0 instr",   32'(instr2),       32'(mem_word(16'hFFFF)));
    check("wrap f0 pc_out",  32'(pc_out2),      32'h0000FFFF);
    step();
    check("wrap req1 addr",  32'(imem_addr2), 32'h0);
    step();
    check("wrap f1 instr",   32'(instr2),  32'h1111);
    check("wrap f1 pc_out",  32'(pc_out2), 32'h0);
    ack2 = 1'b0;

    // Table: zero-wait memory, ack stall, branch, halt.
    //       ex ak hl ps target    req addr      vl instr                pc_out    run
    add_vec(1, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000,           16'h0000, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0001, 1, 16'h1111,           16'h0000, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000,           16'h0000, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0002, 1, 16'h2222,           16'h0001, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000,           16'h0001, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h3333,           16'h0002, 1);
    for (int k = 0; k < 5; k++)
      add_vec(0, 0, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h3333,         16'h0002, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 1, 16'h0003, 0, 16'h0000,           16'h0002, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0004, 1, mem_word(16'h0003), 16'h0003, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000,           16'h0003, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0005, 1, mem_word(16'h0004), 16'h0004, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000,           16'h0004, 1);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0006, 1, mem_word(16'h0005), 16'h0005, 1);
    add_vec(0, 1, 0, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000,           16'h0005, 1);
    add_vec(0, 1, 0, 1, 16'h0099, 0, 16'h0041, 1, mem_word(16'h0040), 16'h0040, 1);
    add_vec(0, 1, 1, 1, 16'h0077, 0, 16'h0041, 0, 16'h0000,           16'h0040, 0);
    add_vec(1, 0, 0, 0, 16'h0000, 0, 16'h0041, 0, 16'h0000,           16'h0040, 0);
    add_vec(0, 1, 0, 0, 16'h0000, 0, 16'h0041, 0, 16'h0000,           16'h0040, 0);

    do_reset();
    wait_cfg = 0;
    foreach (vecs[i]) begin
      exec = vecs[i].exec; instr_ack = vecs[i].ack; halt = vecs[i].halt;
      pc_src = vecs[i].pc_src; branch_target = vecs[i].target;
      step();
      chk_main($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
               vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc_out, vecs[i].e_run);
    end
    exec = 1'b0; instr_ack = 1'b0; halt = 1'b0; pc_src = 1'b0;

    // Three wait cycles, exec pulse during WAIT pauses after the ack.
    do_reset();
    wait_cfg = 3;
    exec = 1'b1;
    step();
    exec = 1'b0;
    chk_main("wait c0", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    chk_main("wait c1", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    exec = 1'b1;
    step();
    exec = 1'b0;
    chk_main("wait c2", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    chk_main("wait c3", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    chk_main("wait done", 1'b0, 16'h0001, 1'b1, 16'h1111, 16'h0000, 1'b1);
    step();
    chk_main("pause hold", 1'b0, 16'h0001, 1'b1, 16'h1111, 16'h0000, 1'b1);
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    chk_main("pause idle", 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    chk_main("pause stay", 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0);
    exec = 1'b1;
    step();
    exec = 1'b0;
    chk_main("resume req", 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    chk_main("resume wait", 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of WAIT.
    #2 reset = 1'b0;
    #1;
    chk_main("async rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    @(negedge clock) reset = 1'b1;
    wait_cfg = 0;
    step();
    exec = 1'b1;
    step();
    exec = 1'b0;
    chk_main("post rst req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    chk_main("post rst f0", 1'b0, 16'h0001, 1'b1, 16'h1111, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
